hilo_muldiv_unit: RTL and testbench
===================================

Name: hilo_muldiv_unit

Overview:
Execute-stage multi-cycle multiply/divide unit for MULT/MULTU/DIV/DIVU.
- Produces the write_hilo_t record that travels down E/M/W and is consumed by HILO forwarding and the HILO register file.
- Holds a single operation at a time and raises busy so pipeline control can stall decode/execute until the result is ready.

Parameters:
MUL_LATENCY, 2, cycles from the start-sample edge to the done cycle for multiplies; must be ≥1.
DIV_CYCLES, 32, divider iterations; fixed at 32 for word_t operands.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  request a new operation; sampled only when busy=0.
op  input  muldiv_op_t (2)  MULT=0, MULTU=1, DIV=2, DIVU=3.
a  input  32  rs operand, dividend or multiplicand.
b  input  32  rt operand, divisor or multiplier.
flush  input  1  abort the in-flight op and discard the result.
busy  output  1  registered; operation in progress.
done  output  1  one-cycle pulse; result valid.
result  output  write_hilo_t  {valid_hi, hi, valid_lo, lo}.

Behaviour:
Reset (async):
- state=IDLE, busy=0, done=0, all result fields 0, iteration counter 0.

States and transitions:
- IDLE: start && !flush → MUL or DIV by op; latch a, b and op.
- MUL: counter runs 1..MUL_LATENCY-1. On the last count → DONE. If MUL_LATENCY=1, go directly to DONE.
- DIV: one radix-2 restoring step per cycle, DIV_CYCLES cycles → DONE.
- DONE: one cycle, done=1 → IDLE.
  - A new start is accepted in the DONE cycle, since busy=0 there (back-to-back ops).

Timing, with start sampled at the end of cycle 0:
- busy=1 in cycles 1..N-1, where N=MUL_LATENCY for multiplies and N=DIV_CYCLES+1=33 for divides.
- done=1 with busy=0 in cycle N.

Result encoding:
- result.valid_hi and result.valid_lo equal done; both are 0 in every other cycle.
- result.hi and result.lo hold their last value while done=0.

Arithmetic:
- MULT: 64-bit signed product; hi=[63:32], lo=[31:0].
- MULTU: same split, unsigned.
- DIVU: lo=quotient, hi=remainder.
- DIV: divide magnitudes; negate the quotient if sign(a)≠sign(b); remainder takes the sign of a.
  - 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- Divide by zero (any DIV/DIVU with b=0): full latency; lo=0xFFFFFFFF, hi=a.

Boundary conditions:
- flush in any state → IDLE next cycle, busy=0, no done pulse.
- flush and start in the same cycle: flush wins and start is ignored.
- flush in the DONE cycle: done still pulses, because the result was already produced; pipeline control discards it.
- start while busy=1: ignored, latched operands unchanged.
- reset mid-operation: immediate return to IDLE, no done.

Optional Feature:
MULDIV_EARLY_OUT_EN
- Defined: a divide whose |a|<|b| (unsigned compare for DIVU) or whose b=0 skips iteration.
  - DIV state lasts one cycle; done in cycle 2.
  - Result: lo=0, hi=a; for b=0, lo=0xFFFFFFFF, hi=a.
- Undefined: every divide takes the full 33 cycles. Results are identical either way.

Decomposition:
Shared package (mycpu):
- muldiv_op_t enum.
- Existing write_hilo_t struct; word_t.
- muldiv_state_t enum {IDLE, MUL, DIV, DONE}.
- DIV_CYCLES constant.

Sub-module hilo_div_iter:
- Unsigned 32-step restoring divider: remainder/quotient shift registers plus counter.
- Interface: start/flush/busy/done, magnitudes in, quotient and remainder out.
- The top module handles sign fixup, the multiplier and the FSM.

Test Plan:
1. MULT a=0xFFFFFFFF b=2 → cycle 2: done=1, hi=0xFFFFFFFF, lo=0xFFFFFFFE, valid_hi=valid_lo=1; busy=1 only in cycle 1.
2. MULTU a=0xFFFFFFFF b=2 → cycle 2: hi=0x00000001, lo=0xFFFFFFFE.
3. DIVU a=100 b=7 → busy cycles 1..32, done in cycle 33: lo=14, hi=2. DIV a=-7 b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
4. DIV a=0x80000000 b=0xFFFFFFFF → lo=0x80000000, hi=0.
   DIVU b=0 a=5 → lo=0xFFFFFFFF, hi=5, in cycle 33 (cycle 2 with MULDIV_EARLY_OUT_EN).
5. DIVU started, flush at cycle 10 → busy=0 at cycle 11, no done through cycle 40.
   New MULT started at cycle 11 → done at cycle 13.
6. Reset asserted asynchronously mid-DIV (cycle 15) → busy, done and result clear immediately.
   Back-to-back: start in the DONE cycle of a MULT → second done exactly MUL_LATENCY cycles later.

Source files
------------

// File: rtl/hilo_muldiv_unit_pkg.sv
// rtl/hilo_muldiv_unit_pkg.sv - shared types and arithmetic helpers for the HILO multiply/divide unit
package hilo_muldiv_unit_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      OP_MULT  = 2'd0,
      OP_MULTU = 2'd1,
      OP_DIV   = 2'd2,
      OP_DIVU  = 2'd3
   } muldiv_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } muldiv_state_t;

   typedef struct packed {
      logic  valid_hi;
      word_t hi;
      logic  valid_lo;
      word_t lo;
   } write_hilo_t;

   localparam int DIV_CYCLES = 32;

   function automatic word_t magnitude(input word_t w, input logic is_signed);
      return (is_signed && w[31]) ? (~w + 32'd1) : w;
   endfunction

   // Low 64 bits of the extended product are exact for both signed and unsigned operands.
   function automatic logic [63:0] mul64(input word_t x, input word_t y, input logic is_signed);
      logic [63:0] ex;
      logic [63:0] ey;
      ex = {{32{is_signed & x[31]}}, x};
      ey = {{32{is_signed & y[31]}}, y};
      return ex * ey;
   endfunction

   // One restoring step; returns {remainder, quotient}.
   function automatic logic [63:0] div_step(input word_t rem, input word_t quo, input word_t dvs);
      logic [32:0] part;
      logic [32:0] diff;
      part = {rem, quo[31]};
      diff = part - {1'b0, dvs};
      if (part >= {1'b0, dvs}) return {diff[31:0], quo[30:0], 1'b1};
      return {part[31:0], quo[30:0], 1'b0};
   endfunction

endpackage

// File: rtl/hilo_muldiv_unit_div_iter.sv
// rtl/hilo_muldiv_unit_div_iter.sv - unsigned radix-2 restoring divider, one step per cycle
module hilo_div_iter
   import hilo_muldiv_unit_pkg::*;
#(
   parameter int ITERATIONS = DIV_CYCLES
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        flush,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        busy,
   output logic        done,
   output logic [31:0] quotient,
   output logic [31:0] remainder
);

   localparam int CW = $clog2(ITERATIONS + 1);

   logic [CW-1:0] count;
   word_t         dvs_q;
   logic [63:0]   step_first;
   logic [63:0]   step_next;

   // The first step is taken on the start edge, so the final step lands one cycle earlier.
   assign step_first = div_step('0, dividend, divisor);
   assign step_next  = div_step(remainder, quotient, dvs_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy      <= 1'b0;
         done      <= 1'b0;
         count     <= '0;
         dvs_q     <= '0;
         quotient  <= '0;
         remainder <= '0;
      end else begin
         done <= 1'b0;
         if (flush) begin
            busy  <= 1'b0;
            count <= '0;
         end else if (start) begin
            {remainder, quotient} <= step_first;
            dvs_q <= divisor;
            count <= CW'(1);
            if (ITERATIONS == 1) begin
               busy <= 1'b0;
               done <= 1'b1;
            end else begin
               busy <= 1'b1;
            end
         end else if (busy) begin
            {remainder, quotient} <= step_next;
            if (count == CW'(ITERATIONS - 1)) begin
               busy  <= 1'b0;
               done  <= 1'b1;
               count <= '0;
            end else begin
               count <= count + CW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - execute-stage MULT/MULTU/DIV/DIVU unit producing write_hilo_t
// Optional MULDIV_EARLY_OUT_EN: divides with |a|<|b| or b=0 finish without iterating.
module hilo_muldiv_unit
   import hilo_muldiv_unit_pkg::*;
#(
   parameter int MUL_LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  muldiv_op_t  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        flush,
   output logic        busy,
   output logic        done,
   output write_hilo_t result
);

   muldiv_state_t state;
   logic [7:0]    cnt;
   word_t         a_q;
   word_t         b_q;
   word_t         hi_q;
   word_t         lo_q;
   muldiv_op_t    op_q;
   logic          early_q;

   logic          accept;
   logic          early_req;
   logic          div_start;
   logic          div_busy;
   logic          div_done;
   word_t         div_quo;
   word_t         div_rem;
   word_t         mag_a;
   word_t         mag_b;
   word_t         quo_fix;
   word_t         rem_fix;
   logic          neg_q;
   logic          neg_r;
   logic [63:0]   prod_in;
   logic [63:0]   prod_q;

   assign accept = start && !flush && (state == IDLE || state == DONE);
   assign mag_a  = magnitude(a, op == OP_DIV);
   assign mag_b  = magnitude(b, op == OP_DIV);

`ifdef MULDIV_EARLY_OUT_EN
   assign early_req = (b == '0) || (mag_a < mag_b);
`else
   assign early_req = 1'b0;
`endif

   assign div_start = accept && op[1] && !early_req;
   assign prod_in   = mul64(a, b, op == OP_MULT);
   assign prod_q    = mul64(a_q, b_q, op_q == OP_MULT);

   // Remainder follows the dividend's sign; quotient is negated when operand signs differ.
   assign neg_q   = (op_q == OP_DIV) && (a_q[31] ^ b_q[31]);
   assign neg_r   = (op_q == OP_DIV) && a_q[31];
   assign quo_fix = neg_q ? (~div_quo + 32'd1) : div_quo;
   assign rem_fix = neg_r ? (~div_rem + 32'd1) : div_rem;

   hilo_div_iter #(
      .ITERATIONS(DIV_CYCLES)
   ) u_div (
      .clk      (clk),
      .reset    (reset),
      .start    (div_start),
      .flush    (flush),
      .dividend (mag_a),
      .divisor  (mag_b),
      .busy     (div_busy),
      .done     (div_done),
      .quotient (div_quo),
      .remainder(div_rem)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= OP_MULT;
         hi_q    <= '0;
         lo_q    <= '0;
         early_q <= 1'b0;
      end else if (flush) begin
         state   <= IDLE;
         cnt     <= '0;
         early_q <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (accept) begin
                  a_q     <= a;
                  b_q     <= b;
                  op_q    <= op;
                  cnt     <= 8'd1;
                  early_q <= early_req;
                  if (op[1]) begin
                     state <= DIV;
                  end else if (MUL_LATENCY == 1) begin
                     state <= DONE;
                     {hi_q, lo_q} <= prod_in;
                  end else begin
                     state <= MUL;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            MUL: begin
               if (cnt == 8'(MUL_LATENCY - 1)) begin
                  state <= DONE;
                  {hi_q, lo_q} <= prod_q;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            DIV: begin
               if (early_q || div_done) begin
                  state <= DONE;
                  if (b_q == '0) begin
                     hi_q <= a_q;
                     lo_q <= '1;
                  end else if (early_q) begin
                     hi_q <= a_q;
                     lo_q <= '0;
                  end else begin
                     hi_q <= rem_fix;
                     lo_q <= quo_fix;
                  end
               end else if (!div_busy) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy            = (state == MUL) || (state == DIV);
   assign done            = (state == DONE);
   assign result.valid_hi = done;
   assign result.hi       = hi_q;
   assign result.valid_lo = done;
   assign result.lo       = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb/tb_hilo_muldiv_unit.sv - self-checking bench for hilo_muldiv_unit
module tb_hilo_muldiv_unit;
   import hilo_muldiv_unit_pkg::*;

   localparam int ML = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        flush;
   muldiv_op_t  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   write_hilo_t result;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t vecs[10];

   always #5 clk = ~clk;

   hilo_muldiv_unit #(.MUL_LATENCY(ML)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .flush (flush),
      .busy  (busy),
      .done  (done),
      .result(result)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_mag(input logic [31:0] x, input bit sgn);
      longint v;
      v = sgn ? longint'($signed(x)) : longint'({32'b0, x});
      if (v < 0) v = -v;
      return v[31:0];
   endfunction

   function automatic int ref_latency(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      if (o < 2) return ML;
`ifdef MULDIV_EARLY_OUT_EN
      if (y == 0 || ref_mag(x, o == 2) < ref_mag(y, o == 2)) return 2;
`endif
      return DIV_CYCLES + 1;
   endfunction

   // Returns {hi, lo}.
   function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      longint p;
      longint q;
      longint r;
      case (o)
         2'd0: begin
            p = longint'($signed(x)) * longint'($signed(y));
            return p;
         end
         2'd1: begin
            p = longint'({32'b0, x}) * longint'({32'b0, y});
            return p;
         end
         default: begin
            if (y == 0) return {x, 32'hFFFF_FFFF};
            if (o == 2) begin
               q = longint'($signed(x)) / longint'($signed(y));
               r = longint'($signed(x)) % longint'($signed(y));
            end else begin
               q = longint'({32'b0, x}) / longint'({32'b0, y});
               r = longint'({32'b0, x}) % longint'({32'b0, y});
            end
            return {r[31:0], q[31:0]};
         end
      endcase
   endfunction

   // Called at a negedge (cycle 0); returns at the negedge of the done cycle.
   task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] exp, input string name);
      int n;
      int at;
      bit pat_ok;
      n = ref_latency(o, x, y);
      at = -1;
      pat_ok = 1'b1;
      start = 1'b1;
      op = muldiv_op_t'(o);
      a = x;
      b = y;
      for (int c = 1; c <= 40 && at < 0; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) at = c;
         else if (!busy || result.valid_hi || result.valid_lo) pat_ok = 1'b0;
      end
      check({name, " latency"}, 64'(at), 64'(n));
      check({name, " busy_pattern"}, 64'(pat_ok), 64'd1);
      check({name, " busy_at_done"}, 64'(busy), 64'd0);
      check({name, " valid"}, {62'd0, result.valid_hi, result.valid_lo}, 64'd3);
      check({name, " hilo"}, {result.hi, result.lo}, exp);
   endtask

   task automatic seq_flush(input bit restart);
      int spurious;
      bit got_mul;
      spurious = 0;
      got_mul = 1'b0;
      start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (c == 1) start = 1'b0;
         if (c == 10) flush = 1'b1;
         if (c == 11) begin
            flush = 1'b0;
            check("flush busy_cleared", 64'(busy), 64'd0);
            if (restart) begin
               start = 1'b1; op = OP_MULT; a = 32'd3; b = 32'hFFFF_FFFB;
            end
         end
         if (c == 12) start = 1'b0;
         if (done) begin
            if (restart && c == 11 + ML) begin
               got_mul = 1'b1;
               check("flush_restart hilo", {result.hi, result.lo}, 64'hFFFF_FFFF_FFFF_FFF1);
            end else begin
               spurious++;
            end
         end
      end
      check("flush no_done", 64'(spurious), 64'd0);
      if (restart) check("flush_restart done", 64'(got_mul), 64'd1);
   endtask

   initial begin
      int errs_before;
      logic [1:0]  ro;
      logic [31:0] ra;
      logic [31:0] rb;
      int at;
      int cnt_done;

      vecs[0] = '{2'd0, 32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFE};
      vecs[1] = '{2'd1, 32'hFFFF_FFFF, 32'd2,          32'h0000_0001, 32'hFFFF_FFFE};
      vecs[2] = '{2'd3, 32'd100,       32'd7,          32'd2,         32'd14};
      vecs[3] = '{2'd2, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[4] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         32'h8000_0000};
      vecs[5] = '{2'd3, 32'd5,         32'd0,          32'd5,         32'hFFFF_FFFF};
      vecs[6] = '{2'd2, 32'hFFFF_FFFB, 32'd0,          32'hFFFF_FFFB, 32'hFFFF_FFFF};
      vecs[7] = '{2'd0, 32'd7,         32'hFFFF_FFFD,  32'hFFFF_FFFF, 32'hFFFF_FFEB};
      vecs[8] = '{2'd2, 32'd7,         32'hFFFF_FFFE,  32'd1,         32'hFFFF_FFFD};
      vecs[9] = '{2'd0, 32'h8000_0000, 32'h8000_0000,  32'h4000_0000, 32'd0};

      reset = 1'b1; start = 1'b0; flush = 1'b0; op = OP_MULT; a = '0; b = '0;
      repeat (2) @(negedge clk);
      check("reset busy", 64'(busy), 64'd0);
      check("reset done", 64'(done), 64'd0);
      check("reset result", 64'(result), 64'd0);
      reset = 1'b0;
      @(negedge clk);
      check("post_reset idle", {62'd0, busy, done}, 64'd0);

      for (int i = 0; i < 10; i++)
         do_op(vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo}, $sformatf("vec%0d", i));

      // Back-to-back: second start lands in the first op's DONE cycle.
      do_op(2'd0, 32'd3, 32'd5, 64'd15, "b2b_first");
      do_op(2'd1, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, "b2b_second");

      @(negedge clk);
      seq_flush(1'b0);
      seq_flush(1'b1);

      // flush and start together: flush wins
      @(negedge clk);
      start = 1'b1; flush = 1'b1; op = OP_MULT; a = 32'd2; b = 32'd2;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      check("flush_start busy", 64'(busy), 64'd0);
      cnt_done = 0;
      repeat (3) begin
         @(negedge clk);
         if (done) cnt_done++;
      end
      check("flush_start no_done", 64'(cnt_done), 64'd0);

      // start while busy is ignored
      start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
      at = -1;
      for (int c = 1; c <= 40 && at < 0; c++) begin
         @(negedge clk);
         start = (c == 5);
         if (c == 5) begin op = OP_MULT; a = 32'd9; b = 32'd9; end
         if (done) at = c;
      end
      check("busy_start latency", 64'(at), 64'(DIV_CYCLES + 1));
      check("busy_start hilo", {result.hi, result.lo}, {32'd2, 32'd14});

      // flush during DONE: pulse still seen, result held
      @(negedge clk);
      start = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd5;
      @(negedge clk);
      start = 1'b0;
      repeat (ML - 1) @(negedge clk);
      check("flush_done pulse", 64'(done), 64'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_done after", {62'd0, busy, done}, 64'd0);
      check("flush_done hold", {result.hi, result.lo}, 64'd15);

      // asynchronous reset mid-divide
      start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
      for (int c = 1; c <= 15; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      check("rst_mid busy_before", 64'(busy), 64'd1);
      #2 reset = 1'b1;
      #1;
      check("rst_mid busy", 64'(busy), 64'd0);
      check("rst_mid done", 64'(done), 64'd0);
      check("rst_mid result", 64'(result), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      cnt_done = 0;
      repeat (25) begin
         @(negedge clk);
         if (done || busy) cnt_done++;
      end
      check("rst_mid quiet", 64'(cnt_done), 64'd0);

      // randomized ops against the arithmetic reference
      errs_before = n_fail;
      for (int i = 0; i < 30; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         case ($urandom_range(0, 7))
            0:       rb = 32'd0;
            1, 2:    rb = 32'($urandom_range(1, 300));
            3:       rb = ra + 32'($urandom_range(0, 5));
            default: rb = $urandom;
         endcase
         if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 1000));
         do_op(ro, ra, rb, ref_result(ro, ra, rb), $sformatf("rand%0d", i));
      end
      if (n_fail != errs_before) $display("random phase saw %0d bad comparisons", n_fail - errs_before);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
